// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared constants, state encoding and helpers for the brick board
//
// Purpose : common definitions for board_ctrl and board_req_arb.
// Contents: NUM_BLOCKS, IDX_W, FULL_MASK, board_state_t, idx_to_onehot().
package board_pkg;

    localparam int NUM_BLOCKS = 16;
    localparam int IDX_W      = 4;

    localparam logic [NUM_BLOCKS-1:0] FULL_MASK = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_CLEARED = 2'd2,
        ST_RELOAD  = 2'd3
    } board_state_t;

    function automatic logic [NUM_BLOCKS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = NUM_BLOCKS'(1) << idx;
    endfunction

endpackage

// File: rtl/board_req_arb.sv
// rtl/board_req_arb.sv - hit request handshake and fixed-priority requester select
//
// Purpose : samples requests, presents one accepted index per cycle to the
//           board, and returns a one-cycle ack qualified by the board's verdict.
// Macro   : BOARD_CTRL_AUX_REQ_EN adds a second (lower priority) requester.
// Ports   : pclk, reset          clock / synchronous active-high reset
//           i_hit_req, i_hit_idx primary request (held until ack)
//           o_hit_ack, o_hit_valid
//           i_aux_req, i_aux_idx, o_aux_ack, o_aux_valid (macro only)
//           i_eval_valid         board verdict for o_accept_idx this cycle
//           o_accept, o_accept_idx  request sampled this cycle
module board_req_arb
    import board_pkg::*;
(
    input  logic             pclk,
    input  logic             reset,
    input  logic             i_hit_req,
    input  logic [IDX_W-1:0] i_hit_idx,
    output logic             o_hit_ack,
    output logic             o_hit_valid,
`ifdef BOARD_CTRL_AUX_REQ_EN
    input  logic             i_aux_req,
    input  logic [IDX_W-1:0] i_aux_idx,
    output logic             o_aux_ack,
    output logic             o_aux_valid,
`endif
    input  logic             i_eval_valid,
    output logic             o_accept,
    output logic [IDX_W-1:0] o_accept_idx
);

    logic r_hit_ack;
    logic r_hit_valid;
    logic w_hit_sel;

    // While our ack is on the wire the requester is still dropping its
    // request, so that cycle is never sampled: one accept per two cycles.
    assign w_hit_sel = i_hit_req & ~r_hit_ack;

`ifdef BOARD_CTRL_AUX_REQ_EN
    logic r_aux_ack;
    logic r_aux_valid;
    logic w_aux_sel;

    // aux only gets a turn when hit is not being sampled, so a held hit
    // request yields to aux during its own ack cycle.
    assign w_aux_sel    = i_aux_req & ~r_aux_ack & ~w_hit_sel;
    assign o_accept     = w_hit_sel | w_aux_sel;
    assign o_accept_idx = w_hit_sel ? i_hit_idx : i_aux_idx;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_aux_ack   <= 1'b0;
            r_aux_valid <= 1'b0;
        end else begin
            r_aux_ack   <= w_aux_sel;
            r_aux_valid <= w_aux_sel & i_eval_valid;
        end
    end

    assign o_aux_ack   = r_aux_ack;
    assign o_aux_valid = r_aux_valid;
`else
    assign o_accept     = w_hit_sel;
    assign o_accept_idx = i_hit_idx;
`endif

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_hit_ack   <= 1'b0;
            r_hit_valid <= 1'b0;
        end else begin
            r_hit_ack   <= w_hit_sel;
            r_hit_valid <= w_hit_sel & i_eval_valid;
        end
    end

    assign o_hit_ack   = r_hit_ack;
    assign o_hit_valid = r_hit_valid;

endmodule

// File: rtl/board_ctrl.sv
// rtl/board_ctrl.sv - 4x4 brick map owner: hit queueing, vblank commit, score, level FSM
//
// Purpose : queues block hits as pending destroys and folds them into the
//           displayed mask only on the rising edge of vertical blank.
// Macro   : BOARD_CTRL_AUX_REQ_EN adds the aux_req/aux_idx/aux_ack/aux_valid port set.
// Ports   : pclk, reset                 clock / synchronous active-high reset
//           vblnk_in                    vertical blank, rising edge = commit
//           start                       one-cycle game start (IDLE only)
//           hit_req, hit_idx            collision request / block index
//           hit_ack, hit_valid          one-cycle ack / block was alive
//           blocks_out                  committed destroyed mask (1 = gone)
//           blocks_left                 live blocks incl. pending destroys
//           score_out, level_out        saturating score / wrapping level
//           level_clear                 pulse on entry to CLEARED
//           state_out                   IDLE=0 PLAY=1 CLEARED=2 RELOAD=3
module board_ctrl
    import board_pkg::*;
#(
    parameter int SCORE_W      = 12,
    parameter int POINTS       = 1,
    parameter int CLEAR_FRAMES = 60
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  vblnk_in,
    input  logic                  start,
    input  logic                  hit_req,
    input  logic [IDX_W-1:0]      hit_idx,
    output logic                  hit_ack,
    output logic                  hit_valid,
`ifdef BOARD_CTRL_AUX_REQ_EN
    input  logic                  aux_req,
    input  logic [IDX_W-1:0]      aux_idx,
    output logic                  aux_ack,
    output logic                  aux_valid,
`endif
    output logic [NUM_BLOCKS-1:0] blocks_out,
    output logic [4:0]            blocks_left,
    output logic [SCORE_W-1:0]    score_out,
    output logic [3:0]            level_out,
    output logic                  level_clear,
    output logic [1:0]            state_out
);

    localparam int FC_W = $clog2(CLEAR_FRAMES + 1);

    board_state_t          r_state;
    board_state_t          w_next_state;
    logic                  r_vblnk_q;
    logic [NUM_BLOCKS-1:0] r_blocks;
    logic [NUM_BLOCKS-1:0] r_pending;
    logic [4:0]            r_left;
    logic [SCORE_W-1:0]    r_score;
    logic [3:0]            r_level;
    logic                  r_level_clear;
    logic [FC_W-1:0]       r_frame_cnt;

    logic                  w_vb_rise;
    logic                  w_accept;
    logic [IDX_W-1:0]      w_accept_idx;
    logic [NUM_BLOCKS-1:0] w_onehot;
    logic                  w_eval_valid;
    logic                  w_hit_ok;
    logic [NUM_BLOCKS-1:0] w_new;
    logic [NUM_BLOCKS-1:0] w_commit_mask;
    logic [SCORE_W:0]      w_score_sum;
    logic                  w_frames_done;

    board_req_arb u_arb (
        .pclk         (pclk),
        .reset        (reset),
        .i_hit_req    (hit_req),
        .i_hit_idx    (hit_idx),
        .o_hit_ack    (hit_ack),
        .o_hit_valid  (hit_valid),
`ifdef BOARD_CTRL_AUX_REQ_EN
        .i_aux_req    (aux_req),
        .i_aux_idx    (aux_idx),
        .o_aux_ack    (aux_ack),
        .o_aux_valid  (aux_valid),
`endif
        .i_eval_valid (w_eval_valid),
        .o_accept     (w_accept),
        .o_accept_idx (w_accept_idx)
    );

    assign w_vb_rise = vblnk_in & ~r_vblnk_q;

    // A block is hittable only if it is neither on screen as destroyed nor
    // already queued; this is what rejects duplicates within one frame.
    assign w_onehot      = idx_to_onehot(w_accept_idx);
    assign w_eval_valid  = (r_state == ST_PLAY) && ((w_onehot & (r_blocks | r_pending)) == '0);
    assign w_hit_ok      = w_accept & w_eval_valid;
    assign w_new         = w_hit_ok ? w_onehot : '0;

    // A hit accepted on the commit edge itself goes straight into this commit.
    assign w_commit_mask = r_blocks | r_pending | w_new;

    assign w_score_sum   = {1'b0, r_score} + (SCORE_W + 1)'(POINTS);
    assign w_frames_done = (r_frame_cnt == FC_W'(CLEAR_FRAMES - 1));

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_vb_rise && (w_commit_mask == FULL_MASK)) begin
                    w_next_state = ST_CLEARED;
                end
            end
            ST_CLEARED: begin
                if (w_vb_rise && w_frames_done) begin
                    w_next_state = ST_RELOAD;
                end
            end
            ST_RELOAD: begin
                w_next_state = ST_PLAY;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_vblnk_q     <= 1'b0;
            r_blocks      <= '0;
            r_pending     <= '0;
            r_left        <= 5'(NUM_BLOCKS);
            r_score       <= '0;
            r_level       <= '0;
            r_level_clear <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_vblnk_q     <= vblnk_in;
            r_level_clear <= (r_state == ST_PLAY) && (w_next_state == ST_CLEARED);

            case (r_state)
                ST_IDLE: begin
                    r_blocks  <= '0;
                    r_pending <= '0;
                    if (start) begin
                        r_score <= '0;
                        r_level <= '0;
                    end
                end
                ST_PLAY: begin
                    if (w_hit_ok) begin
                        r_left <= r_left - 5'd1;
                        r_score <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
                    end
                    if (w_vb_rise) begin
                        r_blocks  <= w_commit_mask;
                        r_pending <= '0;
                    end else begin
                        r_pending <= r_pending | w_new;
                    end
                end
                ST_CLEARED: begin
                    if (w_vb_rise) begin
                        r_frame_cnt <= w_frames_done ? '0 : r_frame_cnt + FC_W'(1);
                    end
                end
                ST_RELOAD: begin
                    r_blocks    <= '0;
                    r_pending   <= '0;
                    r_left      <= 5'(NUM_BLOCKS);
                    r_level     <= r_level + 4'd1;
                    r_frame_cnt <= '0;
                end
                default: begin
                    r_pending <= '0;
                end
            endcase
        end
    end

    assign blocks_out  = r_blocks;
    assign blocks_left = r_left;
    assign score_out   = r_score;
    assign level_out   = r_level;
    assign level_clear = r_level_clear;
    assign state_out   = r_state;

endmodule
